// File: rtl/mmio_bus_interconnect_if.sv
// CPU-side memory port of the MMIO interconnect.
// The CPU drives the request; the interconnect returns data and completion.
interface mmio_bus_interconnect_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  byte_mask;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    modport master (
        output mem_addr, mem_wdata, byte_mask, mem_read, mem_write,
        input  mem_rdata, mem_ready, bus_err
    );

    modport slave (
        input  mem_addr, mem_wdata, byte_mask, mem_read, mem_write,
        output mem_rdata, mem_ready, bus_err
    );
endinterface

// File: rtl/mmio_bus_interconnect.sv
// N-slave MMIO interconnect: address decode, per-slave select/write strobe,
// ready handshake with timeout, and sticky error reporting.
module mmio_bus_interconnect #(
    parameter int                    N_SLAVES   = 3,
    parameter logic [N_SLAVES*32-1:0] BASE_ADDRS =
        {32'hFFFF_FFF4, 32'hFFFF_FFF0, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] TOP_ADDRS  =
        {32'hFFFF_FFF7, 32'hFFFF_FFF3, 32'h0000_07FF},
    parameter int                    TIMEOUT    = 16,
    parameter logic [31:0]           ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     reset,
    mmio_bus_interconnect_if.slave   bus,
    output logic [N_SLAVES-1:0]      slv_sel,
    output logic [N_SLAVES-1:0]      slv_write,
    input  logic [N_SLAVES*32-1:0]   slv_rdata,
    input  logic [N_SLAVES-1:0]      slv_ready,
    input  logic                     err_clear,
    output logic                     err_flag,
    output logic [31:0]              err_addr,
    output logic [7:0]               err_count
);
    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        MISS
    } state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [7:0]       cnt, cnt_d;
    logic [IDX_W-1:0] hit_idx;
    logic             hit;
    logic             req;
    logic             err_ev;

    // Walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (bus.mem_addr >= BASE_ADDRS[32*i +: 32] &&
                bus.mem_addr <= TOP_ADDRS[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign req = (bus.mem_read | bus.mem_write) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            sel_q <= sel_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state;
        sel_d         = sel_q;
        cnt_d         = cnt;
        slv_sel       = '0;
        slv_write     = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        bus.bus_err   = 1'b0;
        err_ev        = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        slv_sel[hit_idx]   = 1'b1;
                        slv_write[hit_idx] = bus.mem_write;
                        sel_d              = hit_idx;
                        cnt_d              = '0;
                        state_d            = WAIT;
                    end else begin
                        state_d = MISS;
                    end
                end
            end
            WAIT: begin
                slv_sel[sel_q] = 1'b1;
                bus.mem_rdata  = slv_rdata[32*sel_q +: 32];
                if (slv_ready[sel_q]) begin
                    bus.mem_ready = 1'b1;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    bus.mem_ready = 1'b1;
                    bus.bus_err   = 1'b1;
                    bus.mem_rdata = ERR_DATA;
                    err_ev        = 1'b1;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            MISS: begin
                bus.mem_ready = 1'b1;
                bus.bus_err   = 1'b1;
                bus.mem_rdata = ERR_DATA;
                err_ev        = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new error outranks a same-cycle clear, restarting the count at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag  <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (err_ev) begin
            err_flag <= 1'b1;
            err_addr <= bus.mem_addr;
            if (err_clear)
                err_count <= 8'd1;
            else if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end else if (err_clear) begin
            err_flag  <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end
    end
endmodule

// File: tb/tb_mmio_bus_interconnect.sv
// Directed bench for mmio_bus_interconnect: BRAM/GPIO/UART decode,
// misses, timeouts, error counter saturation/clear and mid-access reset.
module tb_mmio_bus_interconnect;
    logic        clk;
    logic        reset;
    logic [2:0]  slv_sel;
    logic [2:0]  slv_write;
    logic [95:0] slv_rdata;
    logic [2:0]  slv_ready;
    logic        uart_rdy;
    logic        err_clear;
    logic        err_flag;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    int vectors;
    int miscompares;

    mmio_bus_interconnect_if bus ();

    mmio_bus_interconnect dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .slv_sel   (slv_sel),
        .slv_write (slv_write),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready),
        .err_clear (err_clear),
        .err_flag  (err_flag),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign slv_rdata = {32'hCAFE_0002, 32'h0000_00A5, 32'h1234_5678};
    assign slv_ready = {uart_rdy, 1'b1, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        err_clear     = 1'b0;
        uart_rdy      = 1'b1;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.byte_mask = 4'h0;
        idle_bus();
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_sel", 32'(slv_sel), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        chk("rst_errflag", 32'(err_flag), 32'd0);
        reset = 1'b0;

        // BRAM read, ready tied high
        @(negedge clk);
        bus.mem_addr = 32'h0000_0100;
        bus.mem_read = 1'b1;
        #1;
        chk("rd_sel_accept", 32'(slv_sel), 32'h1);
        chk("rd_wr_accept", 32'(slv_write), 32'h0);
        @(negedge clk);
        chk("rd_ready", 32'(bus.mem_ready), 32'd1);
        chk("rd_rdata", bus.mem_rdata, 32'h1234_5678);
        chk("rd_err", 32'(bus.bus_err), 32'd0);
        idle_bus();
        @(negedge clk);
        chk("rd_done_ready", 32'(bus.mem_ready), 32'd0);
        chk("rd_done_rdata", bus.mem_rdata, 32'd0);

        // GPIO write, strobe only in the accept cycle
        bus.mem_addr  = 32'hFFFF_FFF0;
        bus.mem_wdata = 32'h0000_0055;
        bus.byte_mask = 4'b0001;
        bus.mem_write = 1'b1;
        #1;
        chk("wr_strobe", 32'(slv_write), 32'h2);
        chk("wr_sel", 32'(slv_sel), 32'h2);
        @(negedge clk);
        chk("wr_strobe_gone", 32'(slv_write), 32'h0);
        chk("wr_ready", 32'(bus.mem_ready), 32'd1);
        chk("wr_err", 32'(bus.bus_err), 32'd0);
        idle_bus();

        // Unmapped read
        @(negedge clk);
        bus.mem_addr = 32'h0000_1000;
        bus.mem_read = 1'b1;
        #1;
        chk("miss_sel", 32'(slv_sel), 32'h0);
        @(negedge clk);
        chk("miss_ready", 32'(bus.mem_ready), 32'd1);
        chk("miss_err", 32'(bus.bus_err), 32'd1);
        chk("miss_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
        idle_bus();
        @(negedge clk);
        chk("miss_flag", 32'(err_flag), 32'd1);
        chk("miss_addr", err_addr, 32'h0000_1000);
        chk("miss_count", 32'(err_count), 32'd1);

        // UART never ready: timeout after 16 WAIT cycles
        uart_rdy     = 1'b0;
        bus.mem_addr = 32'hFFFF_FFF4;
        bus.mem_read = 1'b1;
        @(negedge clk);
        chk("to_wait_rdata", bus.mem_rdata, 32'hCAFE_0002);
        for (int k = 2; k <= 15; k++) begin
            @(negedge clk);
            chk("to_wait_ready", 32'(bus.mem_ready), 32'd0);
        end
        @(negedge clk);
        chk("to_ready", 32'(bus.mem_ready), 32'd1);
        chk("to_err", 32'(bus.bus_err), 32'd1);
        chk("to_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
        idle_bus();
        @(negedge clk);
        chk("to_count", 32'(err_count), 32'd2);
        chk("to_addr", err_addr, 32'hFFFF_FFF4);

        // UART ready exactly on the 16th WAIT cycle
        bus.mem_read = 1'b1;
        repeat (16) @(negedge clk);
        uart_rdy = 1'b1;
        #1;
        chk("late_ready", 32'(bus.mem_ready), 32'd1);
        chk("late_err", 32'(bus.bus_err), 32'd0);
        chk("late_rdata", bus.mem_rdata, 32'hCAFE_0002);
        idle_bus();
        @(negedge clk);
        chk("late_count", 32'(err_count), 32'd2);

        // Back-to-back misses saturate the counter
        bus.mem_addr = 32'h0000_1000;
        bus.mem_read = 1'b1;
        repeat (512) @(negedge clk);
        idle_bus();
        @(negedge clk);
        chk("sat_count", 32'(err_count), 32'd255);
        chk("sat_flag", 32'(err_flag), 32'd1);

        // Clear coinciding with a miss: the miss wins
        bus.mem_addr = 32'h0000_2000;
        bus.mem_read = 1'b1;
        @(negedge clk);
        err_clear = 1'b1;
        idle_bus();
        @(negedge clk);
        err_clear = 1'b0;
        chk("clrmiss_count", 32'(err_count), 32'd1);
        chk("clrmiss_flag", 32'(err_flag), 32'd1);
        chk("clrmiss_addr", err_addr, 32'h0000_2000);

        // Reset in the middle of a UART wait
        uart_rdy     = 1'b0;
        bus.mem_addr = 32'hFFFF_FFF4;
        bus.mem_read = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_sel", 32'(slv_sel), 32'h4);
        reset = 1'b1;
        idle_bus();
        @(negedge clk);
        chk("mid_rst_sel", 32'(slv_sel), 32'h0);
        chk("mid_rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("mid_rst_rdata", bus.mem_rdata, 32'd0);
        chk("mid_rst_count", 32'(err_count), 32'd0);
        chk("mid_rst_flag", 32'(err_flag), 32'd0);
        reset    = 1'b0;
        uart_rdy = 1'b1;
        @(negedge clk);
        bus.mem_addr = 32'h0000_0200;
        bus.mem_read = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.mem_ready), 32'd1);
        chk("post_rst_rdata", bus.mem_rdata, 32'h1234_5678);
        idle_bus();

        // Plain clear after a fresh miss
        @(negedge clk);
        bus.mem_addr = 32'h0000_3000;
        bus.mem_read = 1'b1;
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        chk("pre_clr_count", 32'(err_count), 32'd1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("clr_count", 32'(err_count), 32'd0);
        chk("clr_flag", 32'(err_flag), 32'd0);
        chk("clr_addr", err_addr, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
